instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly downstream of the PC register. It takes the current `pc` and issues one word read per instruction to instruction memory over a valid/ready request channel. Returned words are buffered with their PC in a 2-entry FIFO and presented to decode over a valid/ready handshake. It drives `pc_en` so the PC advances only when a fetch is accepted. On `flush` (taken branch) it discards everything queued or in flight.

## Interface
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pc`  in  ADDR_W  current PC from the PC register.
- `flush`  in  1  taken branch; asserted in the same cycle the PC register's `branch` is asserted.
- `pc_en`  out  1  one-cycle pulse: PC register advances to pc+4.
- `mem_req_valid`  out  1  fetch request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  ADDR_W  word address `{pc[ADDR_W-1:2],2'b00}`.
- `mem_rsp_valid`  in  1  read data valid (one per accepted request, in order).
- `mem_rsp_data`  in  DATA_W  read data.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst_data`  out  DATA_W  instruction at FIFO head.
- `inst_pc`  out  ADDR_W  PC of that instruction.
- `fault`  out  1  sticky misaligned-PC fault (see Configuration).

## Operation
- FSM states: IDLE, REQ, WAIT, DISCARD, HALT.
- IDLE: entered on reset; goes to REQ unconditionally on the next clock.
- REQ:
  - `mem_req_valid`=1 when `count` < 2 and `flush`=0 (`count` = FIFO occupancy, 0..2).
  - On handshake (valid and ready both high): latch `pc` into `req_pc`, pulse `pc_en`=1 for that cycle, go to WAIT.
- WAIT: one request outstanding.
  - On `mem_rsp_valid`: push {`mem_rsp_data`, `req_pc`} into the FIFO, go to REQ.
- Credit rule: at most one request outstanding. REQ never issues when `count`=2, so a response always has a free slot.
- FIFO: 2 entries.
  - Pop on `inst_valid && inst_ready`.
  - Push and pop in the same cycle: `count` unchanged, order preserved.
- Flush (any state): FIFO cleared (`count`:=0, `inst_valid`=0 next cycle). No request is issued in the flush cycle.
  - WAIT with no response in the flush cycle: go to DISCARD.
  - WAIT with a response in the flush cycle: the response is dropped; go to REQ.
  - All other states: go to REQ.
- DISCARD: drop the next `mem_rsp_valid` beat (no push), then go to REQ. A further `flush` while in DISCARD stays in DISCARD.
- HALT: no requests; left only via `flush` (to REQ).
- `inst_data`/`inst_pc` hold their value while `inst_valid`=1 and `inst_ready`=0.
- Reset mid-operation: immediate return to IDLE, FIFO empty, in-flight response ignored (the memory is reset together with this block).

## Timing
- Reset values: `pc_en`=0, `mem_req_valid`=0, `mem_req_addr`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fault`=0, `count`=0, state IDLE.
- `mem_req_valid`/`mem_req_addr` are combinational from state, `count`, `flush` and `pc`.
- `pc_en` is combinational: the request handshake.
- Request accepted in cycle N → `pc` shows pc+4 in N+1.
- Response in cycle M → `inst_valid`=1 in M+1. Next request can issue in M+1.
- Zero-wait memory, decode always ready: 1 instruction per 2 cycles.
- `flush` in cycle F → the first request at the branch target issues in F+1 (from REQ/WAIT-with-response) or after the discarded beat (DISCARD).

## Configuration
- Macro `FETCH_MISALIGN_CHECK_EN`:
  - Defined: in REQ, if `pc[1:0]`≠0 then no request is issued, `fault` is set to 1 (sticky), and the FSM goes to HALT. `fault` is cleared by `flush` or reset.
  - Undefined: `pc[1:0]` is ignored (address forced word-aligned), `fault` is tied to 0, and HALT is unreachable.

## Test plan
- Reset release, `pc`=0x1234, `mem_req_ready`=1, response 1 cycle later with 0xDEADBEEF → `pc_en` pulse; `inst_valid`=1 with `inst_data`=0xDEADBEEF and `inst_pc`=0x1234.
- `inst_ready`=0, 3 fetches attempted → exactly 2 entries buffered, no third request, `pc_en` pulses exactly twice; raising `inst_ready` drains them in order.
- `flush` while in WAIT, response arrives 2 cycles later → response dropped, `inst_valid` stays 0, next request uses the new `pc`.
- `flush` in the same cycle as `mem_rsp_valid` → no push, request at the new `pc` next cycle, FIFO empty.
- Push and pop in the same cycle with `count`=1 → `count` stays 1, `inst_pc` advances to the next entry.
- With `FETCH_MISALIGN_CHECK_EN`, `pc`=0x1236 → `fault`=1, no `mem_req_valid`; `flush` with `pc`=0x1238 → `fault`=0 and fetching resumes.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one word read per instruction, buffers returned
// words with their PC in a 2-entry FIFO for decode. Optional: FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              pc_en,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fault,
    output logic [2:0]        dbg_state,
    output logic [1:0]        dbg_count
);

    // Handshakes: a transfer happens in any cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DISCARD = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [DATA_W-1:0] slot0_data_q, slot0_data_d;
    logic [ADDR_W-1:0] slot0_pc_q, slot0_pc_d;
    logic [DATA_W-1:0] slot1_data_q, slot1_data_d;
    logic [ADDR_W-1:0] slot1_pc_q, slot1_pc_d;

    logic pc_misaligned;
    logic push;
    logic pop;
    logic req_fire;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign fault         = fault_q;

    always_comb begin
        fault_d = fault_q;
        if (flush) begin
            fault_d = 1'b0;
        end else if (state_q == S_REQ && pc_misaligned) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    // Low PC bits are ignored: the request address is always word aligned.
    logic unused_pc_lo;
    assign unused_pc_lo  = ^pc[1:0];
    assign pc_misaligned = 1'b0;
    assign fault         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_REQ;
                end else if (pc_misaligned) begin
                    state_d = S_HALT;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = mem_rsp_valid ? S_REQ : S_DISCARD;
                end else if (mem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                // A beat arriving here is always the stale one, even under a new flush.
                if (mem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                if (flush) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        push          = 1'b0;
        if (state_q == S_REQ && count_q != 2'd2 && !flush && !pc_misaligned) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {pc[ADDR_W-1:2], 2'b00};
        end
        if (state_q == S_WAIT && mem_rsp_valid && !flush) begin
            push = 1'b1;
        end
    end

    assign req_fire   = mem_req_valid && mem_req_ready;
    assign pc_en      = req_fire;
    assign inst_valid = (count_q != 2'd0);
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = slot0_data_q;
    assign inst_pc    = slot0_pc_q;
    assign dbg_state  = state_q;
    assign dbg_count  = count_q;

    always_comb begin
        req_pc_d = req_pc_q;
        if (req_fire) begin
            req_pc_d = pc;
        end
    end

    // FIFO: slot0 is always the head, so a pop shifts slot1 forward.
    always_comb begin
        count_d      = count_q;
        slot0_data_d = slot0_data_q;
        slot0_pc_d   = slot0_pc_q;
        slot1_data_d = slot1_data_q;
        slot1_pc_d   = slot1_pc_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                slot0_data_d = slot1_data_q;
                slot0_pc_d   = slot1_pc_q;
            end
            if (push && (count_q != 2'd2 || pop)) begin
                if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                    slot0_data_d = mem_rsp_data;
                    slot0_pc_d   = req_pc_q;
                end else begin
                    slot1_data_d = mem_rsp_data;
                    slot1_pc_d   = req_pc_q;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            req_pc_q     <= '0;
            slot0_data_q <= '0;
            slot0_pc_q   <= '0;
            slot1_data_q <= '0;
            slot1_pc_q   <= '0;
        end else begin
            count_q      <= count_d;
            req_pc_q     <= req_pc_d;
            slot0_data_q <= slot0_data_d;
            slot0_pc_q   <= slot0_pc_d;
            slot1_data_q <= slot1_data_d;
            slot1_pc_q   <= slot1_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, fetch latency, FIFO full/drain,
// flush in WAIT and with a response, push+pop, misalignment and mid-run reset.
module tb_instr_fetch;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_DISCARD = 3'd3;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              pc_en;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              fault;
    logic [2:0]        dbg_state;
    logic [1:0]        dbg_count;

    int checks   = 0;
    int failures = 0;
    int pc_en_pulses;

    instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .flush         (flush),
        .pc_en         (pc_en),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .fault         (fault),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_en_pulses <= 0;
        else if (pc_en) pc_en_pulses <= pc_en_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; pc = 32'h1234; flush = 1'b0; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
        tick(); tick();
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_pc_en", pc_en, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_count", dbg_count, 2'd0);

        // First fetch at 0x1234, zero-wait response
        rst_n = 1'b1;
        tick(); settle();
        chk("t1_state_req", dbg_state, ST_REQ);
        chk("t1_req_valid", mem_req_valid, 1'b1);
        chk("t1_pc_en", pc_en, 1'b1);
        chk("t1_req_addr", mem_req_addr, 32'h1234);
        tick();
        pc = 32'h1238; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF; settle();
        chk("t1_wait_no_req", mem_req_valid, 1'b0);
        chk("t1_wait_no_pc_en", pc_en, 1'b0);
        tick();
        mem_rsp_valid = 1'b0; settle();
        chk("t1_inst_valid", inst_valid, 1'b1);
        chk("t1_inst_data", inst_data, 32'hDEADBEEF);
        chk("t1_inst_pc", inst_pc, 32'h1234);
        chk("t1_count", dbg_count, 2'd1);

        // Decode stalled: second fetch fills FIFO, third is blocked
        chk("t2_req_addr", mem_req_addr, 32'h1238);
        chk("t2_pc_en", pc_en, 1'b1);
        tick();
        pc = 32'h123C; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11111111; settle();
        tick();
        mem_rsp_valid = 1'b0; settle();
        chk("t2_count_full", dbg_count, 2'd2);
        chk("t2_no_third_req", mem_req_valid, 1'b0);
        chk("t2_head_hold", inst_data, 32'hDEADBEEF);
        tick(); tick(); settle();
        chk("t2_still_no_req", mem_req_valid, 1'b0);
        chk("t2_pulses", pc_en_pulses, 2);
        chk("t2_head_pc_hold", inst_pc, 32'h1234);
        mem_req_ready = 1'b0; inst_ready = 1'b1;
        tick(); settle();
        chk("t2_drain1_data", inst_data, 32'h11111111);
        chk("t2_drain1_pc", inst_pc, 32'h1238);
        chk("t2_drain1_count", dbg_count, 2'd1);
        tick(); settle();
        chk("t2_drain2_valid", inst_valid, 1'b0);
        inst_ready = 1'b0;

        // Push and pop in the same cycle with one entry buffered
        mem_req_ready = 1'b1; settle();
        chk("t5_req_addr_a", mem_req_addr, 32'h123C);
        tick();
        pc = 32'h1240; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h22222222; settle();
        tick();
        mem_rsp_valid = 1'b0; settle();
        chk("t5_req_addr_b", mem_req_addr, 32'h1240);
        chk("t5_count_pre", dbg_count, 2'd1);
        tick();
        pc = 32'h1244; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h33333333; inst_ready = 1'b1; settle();
        tick();
        mem_rsp_valid = 1'b0; inst_ready = 1'b0; settle();
        chk("t5_count_same", dbg_count, 2'd1);
        chk("t5_inst_pc", inst_pc, 32'h1240);
        chk("t5_inst_data", inst_data, 32'h33333333);

        // Flush while WAIT, stale response two cycles later
        chk("t3_req_addr", mem_req_addr, 32'h1244);
        tick();
        flush = 1'b1; pc = 32'h1248; settle();
        chk("t3_state_wait", dbg_state, ST_WAIT);
        chk("t3_no_req_flush", mem_req_valid, 1'b0);
        tick();
        flush = 1'b0; pc = 32'h2000; settle();
        chk("t3_state_discard", dbg_state, ST_DISCARD);
        chk("t3_fifo_cleared", inst_valid, 1'b0);
        chk("t3_no_req_discard", mem_req_valid, 1'b0);
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0; settle();
        tick();
        mem_rsp_valid = 1'b0; settle();
        chk("t3_dropped_valid", inst_valid, 1'b0);
        chk("t3_dropped_count", dbg_count, 2'd0);
        chk("t3_new_req", mem_req_valid, 1'b1);
        chk("t3_new_addr", mem_req_addr, 32'h2000);

        // Flush coincident with the response
        tick();
        pc = 32'h2004; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D; flush = 1'b1; settle();
        tick();
        mem_rsp_valid = 1'b0; flush = 1'b0; pc = 32'h3000; settle();
        chk("t4_state_req", dbg_state, ST_REQ);
        chk("t4_count", dbg_count, 2'd0);
        chk("t4_inst_valid", inst_valid, 1'b0);
        chk("t4_pc_en", pc_en, 1'b1);
        chk("t4_addr", mem_req_addr, 32'h3000);
        tick();
        pc = 32'h3004; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h44444444; settle();
        tick();
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; settle();
        chk("t4_push_data", inst_data, 32'h44444444);
        chk("t4_push_pc", inst_pc, 32'h3000);

        // Misaligned PC
        pc = 32'h1236; settle();
`ifdef FETCH_MISALIGN_CHECK_EN
        mem_req_ready = 1'b1; settle();
        chk("t6_no_req", mem_req_valid, 1'b0);
        chk("t6_no_pc_en", pc_en, 1'b0);
        tick(); settle();
        chk("t6_fault_set", fault, 1'b1);
        tick(); settle();
        chk("t6_fault_sticky", fault, 1'b1);
        chk("t6_halt_no_req", mem_req_valid, 1'b0);
        flush = 1'b1; settle();
        tick();
        flush = 1'b0; pc = 32'h1238; settle();
        chk("t6_fault_clear", fault, 1'b0);
        chk("t6_resume_req", mem_req_valid, 1'b1);
        chk("t6_resume_addr", mem_req_addr, 32'h1238);
`else
        chk("t6_aligned_req", mem_req_valid, 1'b1);
        chk("t6_aligned_addr", mem_req_addr, 32'h1234);
        chk("t6_fault_zero", fault, 1'b0);
        mem_req_ready = 1'b1; settle();
`endif

        // Reset in the middle of an outstanding fetch
        tick();
        chk("t7_state_wait", dbg_state, ST_WAIT);
        rst_n = 1'b0; settle();
        chk("t7_state_idle", dbg_state, ST_IDLE);
        chk("t7_count", dbg_count, 2'd0);
        chk("t7_inst_valid", inst_valid, 1'b0);
        chk("t7_inst_data", inst_data, 32'h0);
        chk("t7_fault", fault, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
